// File: rtl/syscall_unit.sv
// SPIM-style syscall service unit: print_int / print_string / print_char / exit,
// with a byte-wide request/ack string reader. Define SYSCALL_TRACE_EN for a console trace.
module syscall_unit #(
  parameter int MAX_STR_LEN = 256,
  parameter int CNT_W       = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall_valid,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        int_valid,
  output logic [31:0] int_data,
  input  logic        int_ready,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STR_REQ  = 3'd1,
    STR_EMIT = 3'd2,
    CHR_EMIT = 3'd3,
    INT_EMIT = 3'd4,
    HALT     = 3'd5
  } state_t;

  localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
  localparam logic [31:0] SVC_PRINT_STR  = 32'd4;
  localparam logic [31:0] SVC_EXIT       = 32'd10;
  localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;

  localparam logic [CNT_W:0]   MAX_LEN_C = (CNT_W+1)'(MAX_STR_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [31:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [7:0]          chr_q, chr_d;
  logic signed [31:0]  int_q, int_d;

  function automatic logic svc_known(input logic [31:0] code);
    return (code == SVC_PRINT_INT) || (code == SVC_PRINT_STR) ||
           (code == SVC_EXIT)      || (code == SVC_PRINT_CHAR);
  endfunction

  // True when accepting the current character reaches the per-string limit.
  function automatic logic str_limit(input logic [CNT_W-1:0] cnt);
    return ({1'b0, cnt} + {1'b0, CNT_ONE}) == MAX_LEN_C;
  endfunction

  // ---- state / control registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Payload registers carry no reset; every output that exposes them is gated by its valid.
  always_ff @(posedge clk) begin
    chr_q <= chr_d;
    int_q <= int_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    chr_d   = chr_q;
    int_d   = int_q;
    case (state_q)
      IDLE: begin
        if (syscall_valid) begin
          case (v0)
            SVC_PRINT_INT: begin
              int_d   = a0;
              state_d = INT_EMIT;
            end
            SVC_PRINT_CHAR: begin
              chr_d   = a0[7:0];
              state_d = CHR_EMIT;
            end
            SVC_PRINT_STR: begin
              ptr_d   = a0;
              count_d = '0;
              state_d = STR_REQ;
            end
            SVC_EXIT: state_d = HALT;
            default:  state_d = IDLE;
          endcase
        end
      end
      STR_REQ: begin
        if (mem_ack) begin
          if (mem_rdata == 8'h00) begin
            state_d = IDLE;
          end else begin
            chr_d   = mem_rdata;
            state_d = STR_EMIT;
          end
        end
      end
      STR_EMIT: begin
        if (char_ready) begin
          ptr_d   = ptr_q + 32'd1;
          count_d = count_q + CNT_ONE;
          state_d = str_limit(count_q) ? IDLE : STR_REQ;
        end
      end
      CHR_EMIT: if (char_ready) state_d = IDLE;
      INT_EMIT: if (int_ready)  state_d = IDLE;
      HALT:     state_d = HALT;
      default:  state_d = IDLE;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    mem_req    = 1'b0;
    mem_addr   = '0;
    char_valid = 1'b0;
    char_data  = '0;
    int_valid  = 1'b0;
    int_data   = '0;
    halted     = 1'b0;
    err        = 1'b0;
    // Stall must rise in the strobe cycle itself, before the FSM has left IDLE.
    stall      = (state_q != IDLE) || (syscall_valid && svc_known(v0));
    case (state_q)
      IDLE: err = syscall_valid && !svc_known(v0);
      STR_REQ: begin
        mem_req  = 1'b1;
        mem_addr = ptr_q;
      end
      STR_EMIT: begin
        char_valid = 1'b1;
        char_data  = chr_q;
        err        = char_ready && str_limit(count_q);
      end
      CHR_EMIT: begin
        char_valid = 1'b1;
        char_data  = chr_q;
      end
      INT_EMIT: begin
        int_valid = 1'b1;
        int_data  = int_q;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

`ifdef SYSCALL_TRACE_EN
  always @(posedge clk) begin
    if (!reset) begin
      if (char_valid && char_ready) $display("%c", char_data);
      if (int_valid && int_ready)   $display("%0d", $signed(int_data));
      if (state_q != HALT && state_d == HALT) $display("program halted");
    end
  end
`endif

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: string walk, int/char print, overflow abort,
// unknown code, exit, and asynchronous reset behaviour.
module tb_syscall_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        syscall_valid;
  logic [31:0] v0, a0;
  logic        stall, mem_req, mem_ack, char_valid, char_ready;
  logic        int_valid, int_ready, halted, err;
  logic [31:0] mem_addr, int_data;
  logic [7:0]  mem_rdata, char_data;
  logic        ack_en;

  logic [7:0]  mem [0:1023];

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] chars_q [$];
  logic [31:0] addrs_q [$];
  logic [31:0] ints_q  [$];
  int stall_cnt = 0;
  int err_cnt   = 0;
  int ivld_cnt  = 0;

  syscall_unit #(.MAX_STR_LEN(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .syscall_valid(syscall_valid), .v0(v0), .a0(a0),
    .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .int_valid(int_valid), .int_data(int_data),
    .int_ready(int_ready), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  assign mem_ack   = mem_req & ack_en;
  assign mem_rdata = mem[mem_addr[9:0]];

  always @(negedge clk) begin
    if (!reset) begin
      if (char_valid && char_ready) chars_q.push_back({24'h0, char_data});
      if (mem_req && mem_ack)       addrs_q.push_back(mem_addr);
      if (int_valid && int_ready)   ints_q.push_back(int_data);
      if (stall)     stall_cnt <= stall_cnt + 1;
      if (err)       err_cnt   <= err_cnt + 1;
      if (int_valid) ivld_cnt  <= ivld_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cget(input int i);
    if (i < chars_q.size()) return chars_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] aget(input int i);
    if (i < addrs_q.size()) return addrs_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] iget(input int i);
    if (i < ints_q.size()) return ints_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    int cb, ab, ib, sb, eb, vb;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h48; mem[10'h101] = 8'h69; mem[10'h102] = 8'h00;
    mem[10'h200] = 8'h41; mem[10'h201] = 8'h42; mem[10'h202] = 8'h43;
    mem[10'h203] = 8'h44; mem[10'h204] = 8'h45; mem[10'h205] = 8'h46;
    mem[10'h206] = 8'h00;
    mem[10'h300] = 8'h5A;

    reset = 1'b1; syscall_valid = 1'b0; v0 = '0; a0 = '0;
    char_ready = 1'b0; int_ready = 1'b0; ack_en = 1'b1;
    #3;
    chk("rst_stall",  {31'h0, stall},      32'h0);
    chk("rst_memreq", {31'h0, mem_req},    32'h0);
    chk("rst_cvalid", {31'h0, char_valid}, 32'h0);
    chk("rst_ivalid", {31'h0, int_valid},  32'h0);
    chk("rst_halted", {31'h0, halted},     32'h0);
    chk("rst_addr",   mem_addr,            32'h0);
    tick(); tick();
    reset = 1'b0;

    // unknown code
    tick(); syscall_valid = 1'b1; v0 = 32'd7; a0 = 32'h100;
    @(negedge clk);
    chk("unk_err",    {31'h0, err},     32'h1);
    chk("unk_stall",  {31'h0, stall},   32'h0);
    chk("unk_memreq", {31'h0, mem_req}, 32'h0);
    tick(); syscall_valid = 1'b0;
    @(negedge clk);
    chk("unk_err_drop", {31'h0, err},     32'h0);
    chk("unk_idle_req", {31'h0, mem_req}, 32'h0);

    // print_string "Hi", 1-cycle ack
    cb = chars_q.size(); ab = addrs_q.size(); sb = stall_cnt; eb = err_cnt;
    tick(); syscall_valid = 1'b1; v0 = 32'd4; a0 = 32'h100; char_ready = 1'b1;
    @(negedge clk);
    chk("str_stall0", {31'h0, stall}, 32'h1);
    tick(); syscall_valid = 1'b0;
    repeat (10) tick();
    chk("str_nchar", chars_q.size() - cb, 32'd2);
    chk("str_c0",    cget(cb),     32'h48);
    chk("str_c1",    cget(cb + 1), 32'h69);
    chk("str_nrd",   addrs_q.size() - ab, 32'd3);
    chk("str_a0",    aget(ab),     32'h100);
    chk("str_a1",    aget(ab + 1), 32'h101);
    chk("str_a2",    aget(ab + 2), 32'h102);
    chk("str_stall", stall_cnt - sb, 32'd6);
    chk("str_err",   err_cnt - eb,   32'd0);
    char_ready = 1'b0;

    // print_int -10 with delayed ready
    ib = ints_q.size(); sb = stall_cnt; vb = ivld_cnt;
    tick(); syscall_valid = 1'b1; v0 = 32'd1; a0 = 32'hFFFF_FFF6;
    tick(); syscall_valid = 1'b0;
    @(negedge clk);
    chk("int_valid", {31'h0, int_valid}, 32'h1);
    chk("int_data",  int_data,           32'hFFFF_FFF6);
    repeat (2) tick();
    @(negedge clk);
    chk("int_hold",  int_data, 32'hFFFF_FFF6);
    tick(); int_ready = 1'b1;
    tick(); int_ready = 1'b0;
    @(negedge clk);
    chk("int_stall_drop", {31'h0, stall}, 32'h0);
    chk("int_vld_cyc", ivld_cnt - vb,  32'd4);
    chk("int_stall",   stall_cnt - sb, 32'd5);
    chk("int_value",   iget(ib),       32'hFFFF_FFF6);

    // print_char, second strobe while busy is ignored
    cb = chars_q.size(); ib = ints_q.size(); sb = stall_cnt; vb = ivld_cnt;
    tick(); syscall_valid = 1'b1; v0 = 32'd11; a0 = 32'h1234_5641;
    tick(); v0 = 32'd1; a0 = 32'd5;
    @(negedge clk);
    chk("chr_valid", {31'h0, char_valid}, 32'h1);
    chk("chr_data",  {24'h0, char_data},  32'h41);
    tick(); syscall_valid = 1'b0; char_ready = 1'b1;
    tick(); char_ready = 1'b0;
    repeat (3) tick();
    chk("chr_n",     chars_q.size() - cb, 32'd1);
    chk("chr_c0",    cget(cb),            32'h41);
    chk("chr_noint", ivld_cnt - vb,       32'd0);
    chk("chr_stall", stall_cnt - sb,      32'd3);

    // overflow: limit 4, "ABCDEF"
    cb = chars_q.size(); ab = addrs_q.size(); eb = err_cnt;
    tick(); syscall_valid = 1'b1; v0 = 32'd4; a0 = 32'h200; char_ready = 1'b1;
    tick(); syscall_valid = 1'b0;
    repeat (7) tick();
    @(negedge clk);
    chk("ovf_err_pulse", {31'h0, err},      32'h1);
    chk("ovf_last_chr",  {24'h0, char_data}, 32'h44);
    repeat (4) tick();
    chk("ovf_nchar", chars_q.size() - cb, 32'd4);
    chk("ovf_c0",    cget(cb),     32'h41);
    chk("ovf_c3",    cget(cb + 3), 32'h44);
    chk("ovf_nrd",   addrs_q.size() - ab, 32'd4);
    chk("ovf_a3",    aget(ab + 3), 32'h203);
    chk("ovf_err",   err_cnt - eb, 32'd1);
    chk("ovf_idle",  {31'h0, stall}, 32'h0);
    char_ready = 1'b0;

    // reset while a read is outstanding
    ack_en = 1'b0;
    tick(); syscall_valid = 1'b1; v0 = 32'd4; a0 = 32'h300;
    tick(); syscall_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rq_req",  {31'h0, mem_req}, 32'h1);
    chk("rq_addr", mem_addr,         32'h300);
    #1 reset = 1'b1;
    #1;
    chk("rq_req_async",   {31'h0, mem_req}, 32'h0);
    chk("rq_stall_async", {31'h0, stall},   32'h0);
    tick(); reset = 1'b0; ack_en = 1'b1;

    // exit
    tick(); syscall_valid = 1'b1; v0 = 32'd10; a0 = 32'h0;
    tick(); syscall_valid = 1'b0;
    @(negedge clk);
    chk("halt_flag",  {31'h0, halted}, 32'h1);
    chk("halt_stall", {31'h0, stall},  32'h1);
    cb = chars_q.size();
    tick(); syscall_valid = 1'b1; v0 = 32'd11; a0 = 32'h42; char_ready = 1'b1;
    tick(); syscall_valid = 1'b0;
    repeat (3) tick();
    chk("halt_stays",  {31'h0, halted},     32'h1);
    chk("halt_nochar", chars_q.size() - cb, 32'd0);
    chk("halt_cvalid", {31'h0, char_valid}, 32'h0);
    #1 reset = 1'b1;
    #1;
    chk("halt_rst_flag",  {31'h0, halted}, 32'h0);
    chk("halt_rst_stall", {31'h0, stall},  32'h0);
    tick(); reset = 1'b0; char_ready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/syscall_unit.md
Name: syscall_unit

Overview:
- Execute-side consumer of the decoder's syscall_control strobe.
- Services MIPS SPIM-style syscalls selected by $v0:
  - 1 print_int
  - 4 print_string
  - 11 print_char
  - 10 exit
- Walks null-terminated strings byte by byte through a request/ack memory port and emits characters on a valid/ready console stream.
- Holds the pipeline stalled until each service completes.

Parameters:
- MAX_STR_LEN, 256: maximum characters emitted per print_string before forced abort.
- CNT_W, 9: width of the internal character counter; must satisfy 2^CNT_W > MAX_STR_LEN.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- syscall_valid  in  1  syscall strobe from control decode; one cycle per syscall instruction.
- v0  in  32  service code (register $2) at strobe time.
- a0  in  32  argument (register $4): int value, char in [7:0], or string base address.
- stall  out  1  freeze upstream pipeline stages.
- mem_req  out  1  byte read request.
- mem_addr  out  32  byte address of the request.
- mem_ack  in  1  read complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  8  returned byte.
- char_valid  out  1  console character available.
- char_data  out  8  console character.
- char_ready  in  1  console accepts the character.
- int_valid  out  1  console integer available.
- int_data  out  32  signed integer to print.
- int_ready  in  1  console accepts the integer.
- halted  out  1  exit syscall executed; sticky until reset.
- err  out  1  one-cycle pulse on an unknown code or string overflow.

Behaviour:
- Reset (asynchronous): state=IDLE; ptr=0; count=0; all outputs 0.
- States: IDLE, STR_REQ, STR_EMIT, CHR_EMIT, INT_EMIT, HALT.
- stall, combinational: (state != IDLE) OR (syscall_valid AND v0 in {1,4,10,11}). There is no bubble between the strobe and the stall.
- syscall_valid is sampled only in IDLE and ignored in every other state.
- IDLE dispatch on syscall_valid:
  - v0=1: latch a0 -> INT_EMIT.
  - v0=11: latch a0[7:0] -> CHR_EMIT.
  - v0=4: ptr<=a0, count<=0 -> STR_REQ.
  - v0=10: -> HALT.
  - Any other code: err=1 for one cycle, remain IDLE, no stall.
- INT_EMIT: int_valid=1 and int_data held stable until int_ready=1, then -> IDLE.
- CHR_EMIT: char_valid=1 and char_data held stable until char_ready=1, then -> IDLE.
- STR_REQ:
  - mem_req=1 and mem_addr=ptr, held until mem_ack=1.
  - On ack, byte 0x00 -> IDLE; nothing is emitted.
  - On ack, nonzero byte -> latch it -> STR_EMIT.
  - An ack in the same cycle the request is first raised is legal: a 1-cycle read.
- STR_EMIT:
  - char_valid=1 with the latched byte.
  - On char_ready: ptr<=ptr+1 (mod 2^32; address 0xFFFFFFFF wraps to 0), count<=count+1.
  - If count+1 == MAX_STR_LEN: err pulse, -> IDLE.
  - Otherwise -> STR_REQ.
- Minimum cost per string character is 2 cycles: request/ack, then emit/ready.
- HALT: halted=1, stall=1 permanently; only reset exits.
- The valid/ready outputs never drop without a handshake; data never changes while valid=1.
- mem_req and char_valid are never asserted in the same cycle.
- Reset mid-operation: immediate return to IDLE; any in-flight mem_req or char_valid deasserts asynchronously.

Optional Feature:
- Macro: SYSCALL_TRACE_EN.
- Defined: simulation-only $display on every completed console handshake:
  - characters print as %c;
  - integers print as signed %0d;
  - exit prints "program halted".
- Not defined: no display statements; behaviour and ports are identical either way.

Test Plan:
- print_string, v0=4, a0=0x100, memory "Hi\0", 1-cycle ack, char_ready=1 -> chars 0x48, 0x69 emitted; reads at 0x100, 0x101, 0x102; stall high 6 cycles, then IDLE; err=0.
- print_int, v0=1, a0=0xFFFFFFF6, int_ready low 3 cycles -> int_valid held 4 cycles with int_data=-10; stall drops the cycle after ready.
- print_char, v0=11, a0=0x1234_5641 -> single char 0x41; syscall_valid pulsed again while busy is ignored.
- Overflow with MAX_STR_LEN=4, string "ABCDEF" -> exactly A,B,C,D emitted, err pulse on the 4th accept, return to IDLE.
- v0=10 -> halted=1 and stall=1 persist; a further syscall_valid has no effect; reset asserted -> halted=0, stall=0 asynchronously.
- Unknown code v0=7 -> err one cycle, stall=0, no mem_req; reset asserted mid-STR_REQ -> mem_req falls immediately.
